// File: rtl/branch_seeker_pkg.sv
// Shared definitions for the bracket-matching branch seeker: instruction
// op_codes, seeker FSM states and scan-direction constants.
package branch_seeker_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_INC   = 4'd1,
    OP_DEC   = 4'd2,
    OP_LEFT  = 4'd3,
    OP_RIGHT = 4'd4,
    OP_OUT   = 4'd5,
    OP_IN    = 4'd6,
    OP_CBF   = 4'd7,
    OP_CBB   = 4'd8,
    OP_HALT  = 4'd9
  } op_code;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } seek_state;

  localparam logic SEEK_FORWARD  = 1'b0;
  localparam logic SEEK_BACKWARD = 1'b1;

endpackage

// File: rtl/branch_seeker_depth_counter.sv
// Bracket nesting-depth counter: clears to zero, counts up/down, and reports
// zero and saturated (all-ones) conditions.
module branch_seeker_depth_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero,
  output logic             o_max
);

  logic [WIDTH-1:0] r_count;

  // Increment at max or decrement at zero is held; the FSM never requests either.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_max) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
  assign o_max   = &r_count;

endmodule

// File: rtl/branch_seeker.sv
// Walks instruction memory from a taken CBF/CBB to its matching bracket and
// returns the redirect PC (match address + 1). Two cycles per instruction.
module branch_seeker
  import branch_seeker_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   direction,
  input  logic [ADDR_WIDTH-1:0]  start_pc,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic                   imem_req,
  input  op_code                 imem_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH-1:0]  target_pc,
  output seek_state              o_dbg_state,
  output logic [DEPTH_WIDTH-1:0] o_dbg_depth
);

  seek_state             r_state;
  seek_state             w_next_state;
  logic                  r_dir;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_target;

  logic                  w_addr_load;
  logic [ADDR_WIDTH-1:0] w_addr_d;
  logic [ADDR_WIDTH-1:0] w_stepped;
  logic                  w_at_end;
  logic                  w_start_at_end;
  logic                  w_target_load;
  logic                  w_depth_clear;
  logic                  w_depth_inc;
  logic                  w_depth_dec;
  logic                  w_depth_zero;
  logic                  w_depth_max;
  logic                  w_is_own;
  logic                  w_is_close;

  branch_seeker_depth_counter #(
    .WIDTH (DEPTH_WIDTH)
  ) u_depth (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clear (w_depth_clear),
    .i_inc   (w_depth_inc),
    .i_dec   (w_depth_dec),
    .o_count (o_dbg_depth),
    .o_zero  (w_depth_zero),
    .o_max   (w_depth_max)
  );

  // "Own" bracket deepens the nest in the scan direction; "close" unwinds it.
  assign w_is_own   = (r_dir == SEEK_BACKWARD) ? (imem_data == OP_CBB) : (imem_data == OP_CBF);
  assign w_is_close = (r_dir == SEEK_BACKWARD) ? (imem_data == OP_CBF) : (imem_data == OP_CBB);

  assign w_at_end       = (r_dir == SEEK_BACKWARD) ? (r_addr == '0) : (&r_addr);
  assign w_stepped      = (r_dir == SEEK_BACKWARD) ? (r_addr - 1'b1) : (r_addr + 1'b1);
  assign w_start_at_end = (direction == SEEK_BACKWARD) ? (start_pc == '0) : (&start_pc);

  always_comb begin
    w_next_state  = r_state;
    w_addr_load   = 1'b0;
    w_addr_d      = r_addr;
    w_target_load = 1'b0;
    w_depth_clear = 1'b0;
    w_depth_inc   = 1'b0;
    w_depth_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_depth_clear = 1'b1;
          if (w_start_at_end) begin
            w_next_state = FAIL;
          end else begin
            w_addr_load  = 1'b1;
            w_addr_d     = (direction == SEEK_BACKWARD) ? (start_pc - 1'b1) : (start_pc + 1'b1);
            w_next_state = ISSUE;
          end
        end
      end
      ISSUE: w_next_state = CHECK;
      CHECK: begin
        if (w_is_close && w_depth_zero) begin
          w_target_load = 1'b1;
          w_next_state  = DONE;
        end else if ((w_is_own && w_depth_max) || w_at_end) begin
          w_next_state = FAIL;
        end else begin
          w_addr_load  = 1'b1;
          w_addr_d     = w_stepped;
          w_depth_inc  = w_is_own;
          w_depth_dec  = w_is_close;
          w_next_state = ISSUE;
        end
      end
      DONE:    w_next_state = IDLE;
      FAIL:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_dir    <= SEEK_FORWARD;
      r_addr   <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && start) begin
        r_dir <= direction;
      end
      if (w_addr_load) begin
        r_addr <= w_addr_d;
      end
      if (w_target_load) begin
        r_target <= r_addr + 1'b1;
      end
    end
  end

  assign imem_addr   = r_addr;
  assign imem_req    = (r_state == ISSUE);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign error       = (r_state == FAIL);
  assign target_pc   = r_target;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_branch_seeker.sv
// Bench for branch_seeker: directed scans from the test plan plus random
// balanced bracket programs, checked against a plain walking model.
module tb_branch_seeker;
  import branch_seeker_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          direction;
  logic [AW-1:0] start_pc;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  op_code        imem_data = OP_NOP;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] target_pc;
  seek_state     dbg_state;
  logic [DW-1:0] dbg_depth;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected fetch addresses of the scan in flight.
  logic [AW-1:0] exp_q[$];
  op_code        mem[logic [AW-1:0]];
  logic [AW-1:0] last_target;

  branch_seeker #(
    .ADDR_WIDTH  (AW),
    .DEPTH_WIDTH (DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .direction   (direction),
    .start_pc    (start_pc),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_data   (imem_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .target_pc   (target_pc),
    .o_dbg_state (dbg_state),
    .o_dbg_depth (dbg_depth)
  );

  // ---------------- clock / memory ----------------
  always #5 clock = ~clock;

  function automatic op_code mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a) != 0) return mem[a];
    return OP_NOP;
  endfunction

  always @(posedge clock) begin
    if (imem_req) imem_data <= mem_rd(imem_addr);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk memory with an integer nest depth until the partner bracket.
  function automatic void model_seek(input logic [AW-1:0] pc, input logic dir,
                                     output bit ok, output logic [AW-1:0] tgt, output int n);
    op_code        own, close, op;
    logic [AW-1:0] a;
    int            depth;
    own   = dir ? OP_CBB : OP_CBF;
    close = dir ? OP_CBF : OP_CBB;
    ok    = 1'b0;
    tgt   = last_target;
    n     = 0;
    depth = 0;
    if ((dir && pc == 0) || (!dir && pc == 16'hFFFF)) return;
    a = dir ? pc - 16'd1 : pc + 16'd1;
    while (n < 70000) begin
      exp_q.push_back(a);
      n++;
      op = mem_rd(a);
      if (op == close && depth == 0) begin
        ok  = 1'b1;
        tgt = a + 16'd1;
        return;
      end
      if (op == own) begin
        if (depth == (1 << DW) - 1) return;
        depth++;
      end else if (op == close) begin
        depth--;
      end
      if (dir ? (a == 16'h0000) : (a == 16'hFFFF)) return;
      a = dir ? a - 16'd1 : a + 16'd1;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_seek(input logic [AW-1:0] pc, input logic dir, input bit poke,
                          input logic [AW-1:0] poke_pc);
    bit            ok;
    bit            seen;
    logic [AW-1:0] tgt;
    int            n;
    int            cyc;
    exp_q.delete();
    model_seek(pc, dir, ok, tgt, n);
    start     = 1'b1;
    direction = dir;
    start_pc  = pc;
    @(posedge clock); #1;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 2 * n + 8) begin
      start = (poke && cyc == 2);
      if (poke && cyc == 2) begin
        start_pc  = poke_pc;
        direction = ~dir;
      end
      if (imem_req) begin
        check("fetch_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("fetch_addr", 32'(imem_addr), 32'(exp_q.pop_front()));
      end
      if (done || error) begin
        seen = 1'b1;
        check("done_pulse", 32'(done), 32'(ok));
        check("error_pulse", 32'(error), 32'(!ok));
        check("pulse_cycle", cyc, 2 * n + 1);
        check("busy_in_pulse", 32'(busy), 32'd1);
        check("target_pc", 32'(target_pc), 32'(tgt));
      end else begin
        check("busy_scan", 32'(busy), 32'd1);
        @(posedge clock); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check("pulse_seen", 32'(seen), 32'd1);
    check("fetches_used", exp_q.size(), 0);
    @(posedge clock); #1;
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
    check("error_after", 32'(error), 32'd0);
    check("target_hold", 32'(target_pc), 32'(tgt));
    last_target = tgt;
  endtask

  task automatic gen_random(output logic [AW-1:0] pc, output logic dir);
    logic [AW-1:0] base;
    int            pairs;
    int            open;
    int            pos;
    int            r;
    logic [AW-1:0] br_q[$];
    mem.delete();
    base  = 16'($urandom_range(16, 2000));
    pairs = $urandom_range(1, 6);
    open  = 0;
    pos   = 0;
    while (pairs > 0 || open > 0) begin
      r = $urandom_range(0, 2);
      if (r == 0 && pairs > 0) begin
        mem[base + 16'(pos)] = OP_CBF;
        br_q.push_back(base + 16'(pos));
        pairs--;
        open++;
      end else if (r == 1 && open > 0) begin
        mem[base + 16'(pos)] = OP_CBB;
        br_q.push_back(base + 16'(pos));
        open--;
      end else begin
        mem[base + 16'(pos)] = op_code'($urandom_range(0, 6));
      end
      pos++;
    end
    pc  = br_q[$urandom_range(0, br_q.size() - 1)];
    dir = (mem[pc] == OP_CBB);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] rpc;
    logic          rdir;
    reset       = 1'b1;
    start       = 1'b0;
    direction   = 1'b0;
    start_pc    = '0;
    last_target = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_target", 32'(target_pc), 32'd0);
    check("rst_depth", 32'(dbg_depth), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(posedge clock); #1;

    // Forward simple.
    mem.delete();
    mem[0] = OP_CBF; mem[1] = OP_INC; mem[2] = OP_CBB;
    run_seek(16'd0, SEEK_FORWARD, 1'b0, '0);
    check("fwd_simple_target", 32'(target_pc), 32'd3);

    // Nested forward.
    mem.delete();
    mem[0] = OP_CBF; mem[1] = OP_CBF; mem[2] = OP_DEC;
    mem[3] = OP_CBB; mem[4] = OP_OUT; mem[5] = OP_CBB;
    run_seek(16'd0, SEEK_FORWARD, 1'b0, '0);
    check("nested_target", 32'(target_pc), 32'd6);

    // Backward.
    mem.delete();
    mem[4] = OP_CBF; mem[5] = OP_LEFT; mem[6] = OP_CBB;
    run_seek(16'd6, SEEK_BACKWARD, 1'b0, '0);
    check("bwd_target", 32'(target_pc), 32'd5);

    // Unmatched backward from 2: error after address 0, target holds 5.
    mem.delete();
    mem[2] = OP_CBB;
    run_seek(16'd2, SEEK_BACKWARD, 1'b0, '0);
    check("unmatched_target", 32'(target_pc), 32'd5);

    // Immediate boundary failures and forward wrap.
    run_seek(16'd0, SEEK_BACKWARD, 1'b0, '0);
    run_seek(16'hFFFF, SEEK_FORWARD, 1'b0, '0);
    mem.delete();
    mem[16'hFFFE] = OP_CBF;
    run_seek(16'hFFFE, SEEK_FORWARD, 1'b0, '0);

    // Depth overflow: 256 nested opens after the branch.
    mem.delete();
    for (int i = 0; i <= 256; i++) mem[16'(i)] = OP_CBF;
    run_seek(16'd0, SEEK_FORWARD, 1'b0, '0);

    // Start while busy is ignored.
    mem.delete();
    mem[0] = OP_CBF; mem[1] = OP_INC; mem[2] = OP_CBB;
    mem[8] = OP_CBF; mem[9] = OP_CBB;
    run_seek(16'd0, SEEK_FORWARD, 1'b1, 16'd9);
    check("poke_target", 32'(target_pc), 32'd3);

    // Reset in CHECK aborts silently.
    start     = 1'b1;
    direction = SEEK_FORWARD;
    start_pc  = 16'd0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("mid_state", 32'(dbg_state), 32'(CHECK));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_target", 32'(target_pc), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    last_target = '0;
    run_seek(16'd0, SEEK_FORWARD, 1'b0, '0);

    // Random balanced programs.
    for (int t = 0; t < 12; t++) begin
      gen_random(rpc, rdir);
      run_seek(rpc, rdir, 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
